// File: rtl/keccak_round_ctrl.sv
// Iterative round sequencer for Keccak-f[100]: one external round per cycle, NR rounds per permutation.
// Optional abort port and flush behaviour enabled by defining KECCAK_ROUND_CTRL_ABORT_EN.
module keccak_round_ctrl #(
    parameter int unsigned NR = 16
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [99:0]  in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [99:0]  out_state,
    output logic [99:0]  rf_state,
    output logic [4:0]   rf_round,
    output logic [3:0]   rf_rc,
    input  logic [99:0]  rf_next,
    output logic         busy
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [4:0] LAST_ROUND = 5'(NR - 1);
    localparam logic [7:0] LFSR_SEED  = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [99:0]  kstate_q, kstate_d;
    logic [4:0]   ir_q, ir_d;
    logic [7:0]   lfsr_q, lfsr_d;
    logic         abort_w;
    logic [7:0]   lfsr_s1, lfsr_s2;

`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // One step of the x^8+x^6+x^5+x^4+1 LFSR; bit 0 is the rc(t) output.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
    endfunction

    function automatic logic [7:0] lfsr_step7(input logic [7:0] r);
        logic [7:0] t;
        t = r;
        for (int unsigned i = 0; i < 7; i++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm_q    <= S_IDLE;
            kstate_q <= '0;
            ir_q     <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            fsm_q    <= fsm_d;
            kstate_q <= kstate_d;
            ir_q     <= ir_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        kstate_d = kstate_q;
        ir_d     = ir_q;
        lfsr_d   = lfsr_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    kstate_d = in_state;
                    ir_d     = '0;
                    lfsr_d   = LFSR_SEED;
                    fsm_d    = S_RUN;
                end
            end
            S_RUN: begin
                kstate_d = rf_next;
                ir_d     = ir_q + 5'd1;
                lfsr_d   = lfsr_step7(lfsr_q);
                if (ir_q == LAST_ROUND) begin
                    ir_d  = '0;
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Abort wins over both round progress and the output handshake.
        if (abort_w && (fsm_q != S_IDLE)) begin
            fsm_d    = S_IDLE;
            kstate_d = '0;
            ir_d     = '0;
            lfsr_d   = LFSR_SEED;
        end
    end

    // rf_rc bits 0,1,3 carry rc(7*ir), rc(7*ir+1), rc(7*ir+2).
    always_comb begin
        lfsr_s1  = lfsr_step(lfsr_q);
        lfsr_s2  = lfsr_step(lfsr_s1);
        rf_rc    = '0;
        rf_rc[0] = lfsr_q[0];
        rf_rc[1] = lfsr_s1[0];
        rf_rc[3] = lfsr_s2[0];
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign out_state = kstate_q;
    assign rf_state  = kstate_q;
    assign rf_round  = (fsm_q == S_RUN) ? ir_q : '0;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl: identity and golden Keccak-f[100] round models.
// Abort scenarios are built only when KECCAK_ROUND_CTRL_ABORT_EN is defined.
module tb_keccak_round_ctrl;

    localparam int unsigned NR = 16;

    logic         g_clk = 1'b0;
    logic         g_resetn;
    logic         in_valid;
    logic         in_ready;
    logic [99:0]  in_state;
    logic         out_valid;
    logic         out_ready;
    logic [99:0]  out_state;
    logic [99:0]  rf_state;
    logic [4:0]   rf_round;
    logic [3:0]   rf_rc;
    logic [99:0]  rf_next;
    logic         busy;
    logic         use_model;
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // FIPS 202 RC[0..15], low 4 bits.
    logic [3:0] rc_tab [16] = '{4'h1, 4'h2, 4'hA, 4'h0, 4'hB, 4'h1, 4'h1, 4'h9,
                                4'hA, 4'h8, 4'h9, 4'hA, 4'hB, 4'hB, 4'h9, 4'h3};

    localparam logic [99:0] PAT_A = {4'hC, 96'h0123_4567_89AB_CDEF_FEDC_BA98};
    localparam logic [99:0] PAT_B = {4'h5, 96'hDEAD_BEEF_0F1E_2D3C_4B5A_6978};

    always #5 g_clk = ~g_clk;

    keccak_round_ctrl #(.NR(NR)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .rf_state  (rf_state),
        .rf_round  (rf_round),
        .rf_rc     (rf_rc),
        .rf_next   (rf_next),
        .busy      (busy)
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [3:0] rotl4(input logic [3:0] v, input int n);
        logic [7:0] t;
        t = {v, v} << (n % 4);
        return t[7:4];
    endfunction

    // Reference Keccak-f[100] round; lane (x,y) occupies bits 4*(x+5y) +: 4.
    function automatic logic [99:0] kround(input logic [99:0] s, input logic [3:0] rc);
        logic [3:0]  a [25];
        logic [3:0]  b [25];
        logic [3:0]  c [5];
        logic [3:0]  d [5];
        logic [99:0] o;
        int rho [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
        for (int i = 0; i < 25; i++) a[i] = s[4*i +: 4];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl4(c[(x+1)%5], 1);
        for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y + 5*((2*x + 3*y) % 5)] = rotl4(a[x + 5*y], rho[x + 5*y]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        a[0] = a[0] ^ rc;
        for (int i = 0; i < 25; i++) o[4*i +: 4] = a[i];
        return o;
    endfunction

    always_comb rf_next = use_model ? kround(rf_state, rf_rc) : rf_state;

    task automatic check_eq(input string tag, input logic [99:0] got, input logic [99:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        @(negedge g_clk);
    endtask

    task automatic load(input logic [99:0] p);
        check_eq("load_ready", 100'(in_ready), 100'(1));
        in_valid = 1'b1;
        in_state = p;
        tick();
        in_valid = 1'b0;
        in_state = '0;
    endtask

    task automatic run_rounds(input logic chk_round);
        for (int r = 0; r < int'(NR); r++) begin
            if (chk_round) begin
                check_eq($sformatf("round_idx%0d", r), 100'(rf_round), 100'(r));
                check_eq($sformatf("rc%0d", r), 100'(rf_rc), 100'(rc_tab[r]));
            end
            check_eq($sformatf("no_ovalid%0d", r), 100'(out_valid), 100'(0));
            tick();
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("drain_bound", 100'(in_ready), 100'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [99:0] exp_s;
        int unsigned n;
        int unsigned dones;

        g_resetn  = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        use_model = 1'b0;
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        #2 g_resetn = 1'b0;
        #1;
        check_eq("rst_in_ready",  100'(in_ready),  100'(1));
        check_eq("rst_out_valid", 100'(out_valid), 100'(0));
        check_eq("rst_busy",      100'(busy),      100'(0));
        check_eq("rst_rf_rc",     100'(rf_rc),     100'(4'h1));
        check_eq("rst_rf_round",  100'(rf_round),  100'(0));
        check_eq("rst_out_state", out_state, '0);
        check_eq("rst_rf_state",  rf_state,  '0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        tick();

        // Identity round model: state passes through, sequencing observable.
        load(PAT_A);
        check_eq("run_busy",  100'(busy),     100'(1));
        check_eq("run_ready", 100'(in_ready), 100'(0));
        check_eq("run_state", rf_state, PAT_A);
        run_rounds(1'b1);
        check_eq("id_ovalid",   100'(out_valid), 100'(1));
        check_eq("id_state",    out_state, PAT_A);
        check_eq("done_round0", 100'(rf_round), 100'(0));

        // Backpressure in DONE.
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_ovalid", 100'(out_valid), 100'(1));
            check_eq("bp_ready",  100'(in_ready),  100'(0));
            check_eq("bp_state",  out_state, PAT_A);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("hs_ready",  100'(in_ready),  100'(1));
        check_eq("hs_ovalid", 100'(out_valid), 100'(0));
        check_eq("hs_busy",   100'(busy),      100'(0));
        check_eq("hs_retain", out_state, PAT_A);
        load(PAT_B);
        check_eq("reload_busy",  100'(busy), 100'(1));
        check_eq("reload_state", rf_state, PAT_B);
        run_rounds(1'b0);
        check_eq("reload_out", out_state, PAT_B);
        drain();

        // Golden round model, zero state and a patterned state.
        use_model = 1'b1;
        for (int t = 0; t < 2; t++) begin
            logic [99:0] seed;
            seed  = (t == 0) ? '0 : PAT_A;
            exp_s = seed;
            for (int r = 0; r < int'(NR); r++) exp_s = kround(exp_s, rc_tab[r]);
            load(seed);
            run_rounds(1'b1);
            check_eq($sformatf("gold_ovalid%0d", t), 100'(out_valid), 100'(1));
            check_eq($sformatf("gold_state%0d", t), out_state, exp_s);
            drain();
        end
        use_model = 1'b0;

        // Back-to-back throughput: NR+2 cycles per permutation.
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = PAT_A;
        check_eq("tp_ready0", 100'(in_ready), 100'(1));
        tick();
        n = 0;
        dones = 0;
        while (!in_ready && n < 40) begin
            if (out_valid) dones++;
            tick();
            n++;
        end
        check_eq("tp_gap",   100'(n),     100'(NR + 1));
        check_eq("tp_dones", 100'(dones), 100'(1));
        check_eq("tp_out",   out_state, PAT_A);
        in_state = PAT_B;
        tick();
        in_valid = 1'b0;
        check_eq("tp_accept2", 100'(busy), 100'(1));
        check_eq("tp_state2",  rf_state,   PAT_B);
        drain();

        // Asynchronous reset mid-RUN, then a clean full permutation.
        tick();
        load(PAT_A);
        for (int r = 0; r < 7; r++) tick();
        check_eq("mid_round7", 100'(rf_round), 100'(7));
        #2 g_resetn = 1'b0;
        #1;
        check_eq("mid_ready", 100'(in_ready), 100'(1));
        check_eq("mid_busy",  100'(busy),     100'(0));
        check_eq("mid_state", out_state, '0);
        check_eq("mid_round", 100'(rf_round), 100'(0));
        check_eq("mid_rc",    100'(rf_rc),    100'(4'h1));
        @(negedge g_clk);
        g_resetn = 1'b1;
        tick();
        load(PAT_B);
        run_rounds(1'b1);
        check_eq("post_ovalid", 100'(out_valid), 100'(1));
        check_eq("post_state",  out_state, PAT_B);
        drain();

`ifdef KECCAK_ROUND_CTRL_ABORT_EN
        // Abort at round 5.
        tick();
        load(PAT_A);
        for (int r = 0; r < 5; r++) tick();
        check_eq("ab_round5", 100'(rf_round), 100'(5));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_ready", 100'(in_ready), 100'(1));
        check_eq("ab_state", out_state, '0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) dones++;
            tick();
        end
        check_eq("ab_no_ovalid", 100'(dones), 100'(0));

        // Abort coincident with the output handshake.
        load(PAT_B);
        run_rounds(1'b0);
        check_eq("abd_ovalid", 100'(out_valid), 100'(1));
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check_eq("abd_ready", 100'(in_ready), 100'(1));
        check_eq("abd_state", out_state, '0);

        // Abort in IDLE does not block an accept.
        abort = 1'b1;
        load(PAT_A);
        abort = 1'b0;
        check_eq("abi_busy",  100'(busy), 100'(1));
        check_eq("abi_state", rf_state, PAT_A);
        run_rounds(1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

- Iterative sequencer for the Keccak-f[25·N] permutation (N=4: Keccak-f[100], 16 rounds). It accepts a full state over a valid/ready handshake and holds it in an internal k_state register.
- Each round, it drives the current state, round index and round constant to an external combinational round-function datapath (θ,ρ,π,χ,ι) and captures the result.
- After NR rounds it presents the permuted state over a second valid/ready handshake. It sits between the sponge absorb/squeeze logic and the round datapath.

## Interface
Parameters:
- NR, 16, number of rounds (12+2·log2(N)); 1 ≤ NR ≤ 24.

Ports:
- g_clk  in  1  clock; all state changes on rising edge
- g_resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  input state offered
- in_ready  out  1  controller can accept a state
- in_state  in  k_state  state to permute
- out_valid  out  1  permuted state available
- out_ready  in  1  consumer accepts out_state
- out_state  out  k_state  permuted state (internal register)
- rf_state  out  k_state  state fed to round datapath (same register)
- rf_round  out  5  current round index ir
- rf_rc  out  k_lane  round constant for round ir, truncated to N bits
- rf_next  in  k_state  round datapath result for rf_state/rf_rc
- busy  out  1  high in RUN or DONE
- abort  in  1  only with KECCAK_ROUND_CTRL_ABORT_EN

## Operation
- FSM states: IDLE, RUN, DONE. in_ready=(IDLE); out_valid=(DONE); busy=!IDLE. All outputs are decoded from registers; no combinational in→out paths.
- IDLE:
  - in_valid → state_q<=in_state, ir<=0, rc LFSR<=8'h01, go RUN.
  - in_valid low → hold.
- RUN:
  - Every cycle: state_q<=rf_next, ir<=ir+1, LFSR advances 7 steps.
  - On the cycle where ir==NR-1, capture rf_next, go DONE, ir<=0.
- DONE:
  - state_q is held stable while out_ready is low.
  - out_ready → go IDLE; state_q is retained (not cleared).
- Round constants: rf_rc bit (2^j−1) = rc(j+7·ir) for j=0..log2(N); all other bits are 0. rc(t) is the FIPS 202 Algorithm 5 LFSR (x^8+x^6+x^5+x^4+1, seed 0x01).
  - For N=4, rounds 0..4 give 4'h1, 4'h2, 4'hA, 4'h0, 4'hB.
  - rf_rc must equal the FIPS 202 RC[ir] low N bits for every ir<NR.
- rf_round is 0 in IDLE and DONE; in RUN it equals ir.
- The controller never inspects state contents; the width rules are those of k_lane/k_plane/k_state.
- Reset (asynchronous, any state, including mid-RUN): state_q=0, ir=0, LFSR=8'h01, FSM=IDLE. Reset values: in_ready=1, out_valid=0, busy=0, rf_round=0, rf_rc=4'h1, out_state/rf_state=0.

## Timing
- Accept handshake at edge k. RUN covers edges k+1..k+NR. out_valid is high after edge k+NR: NR cycles of latency.
- One round per cycle. Back-to-back throughput is NR+2 cycles per permutation with out_ready held high:
  - 1 cycle in DONE.
  - 1 cycle in IDLE before the next accept. in_ready is not asserted in the DONE→IDLE handshake cycle.
- in_valid in RUN/DONE is ignored. in_state is not sampled; the source must hold it until in_ready.
- out_valid stays asserted and out_state stays constant until out_ready is sampled high.

## Configuration
- KECCAK_ROUND_CTRL_ABORT_EN defined:
  - abort port exists.
  - abort high in RUN or DONE → next edge: IDLE, state_q=0, ir=0, LFSR=8'h01, out_valid=0.
  - abort has priority over the out handshake in the same cycle.
  - abort in IDLE is ignored; it does not block an accept.
- Macro undefined: no abort port. The FSM leaves RUN only on round completion and DONE only on out_ready.

## Test plan
- Reset idle: assert g_resetn=0 mid-cycle → asynchronously in_ready=1, out_valid=0, busy=0, rf_rc=4'h1, rf_round=0.
- Single permutation, identity round model (rf_next=rf_state): load in_state=pattern at edge k.
  - rf_round steps 0..15.
  - rf_rc follows the FIPS 202 RC low nibbles (1,2,A,0,B,...).
  - out_valid rises after edge k+16 with out_state=pattern.
- Reference model: rf_next = golden Keccak-f[100] round; zero input → out_state matches the golden permutation of the zero state after 16 rounds.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_state stable, in_ready=0. out_ready=1 → IDLE next cycle, accept the following edge.
- Reset mid-RUN at round 7 → immediately IDLE, state 0. A subsequent load completes a full 16 rounds.
- With KECCAK_ROUND_CTRL_ABORT_EN: abort at round 5 → IDLE next cycle, out_valid never rises. abort coincident with an out_ready handshake in DONE → IDLE, state cleared.
